// File: rtl/syncword_correlator.sv
// Receive access-code correlator: slides the rx bit stream through a 64-bit window,
// Hamming-compares it against the mode-selected sync word and flags trailer start.
module syncword_correlator #(
    parameter int SYNC_W = 64,
    parameter int WIN_W  = 12
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              p_1us,
    input  logic              rxbit,
    input  logic              corr_win_open,
    input  logic              corr_abort,
    input  logic              page,
    input  logic              inquiry,
    input  logic              conns,
    input  logic              ps,
    input  logic              mpr,
    input  logic              spr,
    input  logic              regi_inquiryDIAC,
    input  logic [SYNC_W-1:0] regi_syncword_CAC,
    input  logic [SYNC_W-1:0] regi_syncword_DAC,
    input  logic [SYNC_W-1:0] regi_syncword_DIAC,
    input  logic [SYNC_W-1:0] regi_syncword_GIAC,
    input  logic [6:0]        regi_corr_thresh,
    input  logic [WIN_W-1:0]  regi_search_win,
    input  logic [27:0]       CLK,
    output logic              rx_trailer_st_p,
    output logic              sync_found_p,
    output logic              sync_timeout_p,
    output logic              searching,
    output logic [6:0]        corr_errcnt,
    output logic [27:0]       found_clk
);

    // state  | meaning
    // IDLE   | no search in progress
    // SEARCH | shifting bits, comparing one cycle after each sample
    // MATCH  | sync word accepted, waiting for the first trailer sample
    // FOUND  | trailer start issued, returns to IDLE next cycle
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] MATCH  = 2'd2;
    localparam logic [1:0] FOUND  = 2'd3;

    logic [1:0]        r_state;
    logic [SYNC_W-1:0] r_shreg;
    logic [6:0]        r_bitcnt;
    logic [WIN_W-1:0]  r_wincnt;
    logic              r_cmp_pend;
    logic              r_found_p;
    logic              r_timeout_p;
    logic [6:0]        r_errcnt;
    logic [27:0]       r_found_clk;

    logic              w_dac_mode;
    logic              w_inq_mode;
    logic [SYNC_W-1:0] w_sw;
    logic [SYNC_W-1:0] w_diff;
    logic [6:0]        w_err;
    logic              w_match;
    logic              w_timeout;

    // Inquiry and "no mode active" both fall back to the inquiry access codes.
    assign w_dac_mode = ~conns & (page | ps | mpr | spr);
    assign w_inq_mode = ~conns & ~w_dac_mode & (inquiry | ~(page | ps | mpr | spr));

    always_comb begin
        w_sw = regi_syncword_CAC;
        if (w_dac_mode) begin
            w_sw = regi_syncword_DAC;
        end else if (w_inq_mode) begin
            w_sw = regi_inquiryDIAC ? regi_syncword_DIAC : regi_syncword_GIAC;
        end
    end

    assign w_diff = r_shreg ^ w_sw;

    always_comb begin
        w_err = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            w_err = w_err + {6'd0, w_diff[i]};
        end
    end

    assign w_match   = (r_bitcnt == 7'd64) && (w_err <= regi_corr_thresh);
    assign w_timeout = (regi_search_win != '0) && (r_wincnt == regi_search_win);

    // Timeout is resolved in the compare cycle so a match on the same sample can win.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_wincnt    <= '0;
            r_cmp_pend  <= 1'b0;
            r_found_p   <= 1'b0;
            r_timeout_p <= 1'b0;
            r_errcnt    <= '0;
            r_found_clk <= '0;
        end else begin
            r_found_p   <= 1'b0;
            r_timeout_p <= 1'b0;
            r_cmp_pend  <= 1'b0;
            if (corr_abort) begin
                r_state <= IDLE;
            end else if (corr_win_open) begin
                r_state  <= SEARCH;
                r_shreg  <= '0;
                r_bitcnt <= '0;
                r_wincnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    SEARCH: begin
                        if (p_1us) begin
                            r_shreg    <= {r_shreg[SYNC_W-2:0], rxbit};
                            r_cmp_pend <= 1'b1;
                            if (r_bitcnt != 7'd64) begin
                                r_bitcnt <= r_bitcnt + 7'd1;
                            end
                            if (r_wincnt != '1) begin
                                r_wincnt <= r_wincnt + 1'b1;
                            end
                        end else if (r_cmp_pend) begin
                            if (w_match) begin
                                r_state   <= MATCH;
                                r_errcnt  <= w_err;
                                r_found_p <= 1'b1;
                            end else if (w_timeout) begin
                                r_state     <= IDLE;
                                r_timeout_p <= 1'b1;
                            end
                        end
                    end
                    MATCH: begin
                        if (p_1us) begin
                            r_state     <= FOUND;
                            r_found_clk <= CLK;
                        end
                    end
                    FOUND: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_trailer_st_p = (r_state == MATCH) & p_1us & ~corr_abort & ~corr_win_open;
    assign sync_found_p    = r_found_p;
    assign sync_timeout_p  = r_timeout_p;
    assign searching       = (r_state == SEARCH);
    assign corr_errcnt     = r_errcnt;
    assign found_clk       = r_found_clk;

endmodule

// File: tb/tb_syncword_correlator.sv
// Bench for syncword_correlator: expected trailer/timeout events are queued as the
// stream is driven and popped by a monitor when the DUT pulses.
module tb_syncword_correlator;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b1;
    logic        p_1us = 1'b0;
    logic        rxbit = 1'b0;
    logic        corr_win_open = 1'b0;
    logic        corr_abort = 1'b0;
    logic        page = 1'b0, inquiry = 1'b0, conns = 1'b0, ps = 1'b0, mpr = 1'b0, spr = 1'b0;
    logic        regi_inquiryDIAC = 1'b0;
    logic [63:0] cac, dac, diac, giac;
    logic [6:0]  thresh = 7'd0;
    logic [11:0] swin = 12'd0;
    logic [27:0] clk_bt = 28'd0;

    logic        rx_trailer_st_p, sync_found_p, sync_timeout_p, searching;
    logic [6:0]  corr_errcnt;
    logic [27:0] found_clk;

    localparam logic [27:0] CLK_BASE = 28'h0ABC000;
    localparam logic [63:0] FLIP5    = 64'h8000_0100_0002_0401;

    typedef struct {
        int         kind;   // 0 = trailer start, 1 = timeout
        int         strobe;
        logic [6:0] err;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int          checks = 0, errors = 0;
    int          n_strobe = 0, found_cnt = 0, found_strobe = -1;
    bit          fc_pend = 1'b0;
    logic [27:0] fc_exp;

    syncword_correlator #(.SYNC_W(64), .WIN_W(12)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .rxbit(rxbit),
        .corr_win_open(corr_win_open), .corr_abort(corr_abort),
        .page(page), .inquiry(inquiry), .conns(conns), .ps(ps), .mpr(mpr), .spr(spr),
        .regi_inquiryDIAC(regi_inquiryDIAC),
        .regi_syncword_CAC(cac), .regi_syncword_DAC(dac),
        .regi_syncword_DIAC(diac), .regi_syncword_GIAC(giac),
        .regi_corr_thresh(thresh), .regi_search_win(swin), .CLK(clk_bt),
        .rx_trailer_st_p(rx_trailer_st_p), .sync_found_p(sync_found_p),
        .sync_timeout_p(sync_timeout_p), .searching(searching),
        .corr_errcnt(corr_errcnt), .found_clk(found_clk)
    );

    always #5 clk_6M = ~clk_6M;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk_6M) begin
        if (rstz) begin
            if (fc_pend) begin
                checks++;
                if (found_clk !== fc_exp) begin
                    errors++;
                    $display("FAIL found_clk: got %h expected %h", found_clk, fc_exp);
                end
                fc_pend = 1'b0;
            end
            if (sync_found_p === 1'b1) begin
                found_cnt++;
                found_strobe = n_strobe;
            end
            if (rx_trailer_st_p === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_trailer: got pulse at strobe %0d expected none", n_strobe);
                end else begin
                    e_mon = q.pop_front();
                    if (e_mon.kind != 0 || e_mon.strobe != n_strobe) begin
                        errors++;
                        $display("FAIL trailer_timing: got trailer at strobe %0d expected kind %0d at strobe %0d",
                                 n_strobe, e_mon.kind, e_mon.strobe);
                    end
                    checks++;
                    if (corr_errcnt !== e_mon.err) begin
                        errors++;
                        $display("FAIL corr_errcnt: got %0d expected %0d", corr_errcnt, e_mon.err);
                    end
                    checks++;
                    if (found_cnt != 1 || found_strobe != n_strobe - 1) begin
                        errors++;
                        $display("FAIL sync_found_p: got %0d pulses last at strobe %0d expected 1 at strobe %0d",
                                 found_cnt, found_strobe, n_strobe - 1);
                    end
                    fc_pend = 1'b1;
                    fc_exp  = clk_bt;
                end
                found_cnt = 0;
            end
            if (sync_timeout_p === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_timeout: got pulse at strobe %0d expected none", n_strobe);
                end else begin
                    e_mon = q.pop_front();
                    if (e_mon.kind != 1 || e_mon.strobe != n_strobe) begin
                        errors++;
                        $display("FAIL timeout_timing: got timeout at strobe %0d expected kind %0d at strobe %0d",
                                 n_strobe, e_mon.kind, e_mon.strobe);
                    end
                    checks++;
                    if (searching !== 1'b0 || found_cnt != 0) begin
                        errors++;
                        $display("FAIL timeout_state: got searching=%b found=%0d expected 0 and 0",
                                 searching, found_cnt);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic send_bit(input logic b);
        repeat (5) tick();
        p_1us  = 1'b1;
        rxbit  = b;
        n_strobe++;
        clk_bt = CLK_BASE + 28'(n_strobe);
        tick();
        p_1us = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int nbits);
        for (int i = 63; i > 63 - nbits; i--) send_bit(w[i]);
    endtask

    task automatic send_fill(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic send_preamble();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    endtask

    task automatic open_window();
        corr_win_open = 1'b1;
        tick();
        corr_win_open = 1'b0;
        n_strobe  = 0;
        found_cnt = 0;
    endtask

    task automatic push_exp(input int kind, input int strobe, input logic [6:0] err);
        exp_t e;
        e.kind = kind; e.strobe = strobe; e.err = err;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        repeat (20) tick();
        checks++;
        if (q.size() != 0 || found_cnt != 0) begin
            errors++;
            $display("FAIL %s_events: got %0d missing events and %0d stray found pulses expected 0 and 0",
                     name, q.size(), found_cnt);
        end
        q.delete();
        found_cnt = 0;
    endtask

    task automatic test_reset();
        #2 rstz = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (searching !== 1'b0) begin errors++; $display("FAIL reset_searching: got %b expected 0", searching); end
        if (sync_found_p !== 1'b0) begin errors++; $display("FAIL reset_found: got %b expected 0", sync_found_p); end
        if (sync_timeout_p !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", sync_timeout_p); end
        if (rx_trailer_st_p !== 1'b0) begin errors++; $display("FAIL reset_trailer: got %b expected 0", rx_trailer_st_p); end
        if (corr_errcnt !== 7'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", corr_errcnt); end
        if (found_clk !== 28'd0) begin errors++; $display("FAIL reset_found_clk: got %h expected 0", found_clk); end
        rstz = 1'b1;
        tick();
    endtask

    task automatic test_exact();
        conns = 1'b1; thresh = 7'd0; swin = 12'd0;
        open_window();
        send_preamble();
        push_exp(0, 69, 7'd0);
        send_word(cac, 64);
        send_fill(1'b0, 3);
        drain("exact");
        checks++;
        if (searching !== 1'b0) begin errors++; $display("FAIL exact_idle: got searching=%b expected 0", searching); end
    endtask

    task automatic test_errors();
        thresh = 7'd7; swin = 12'd0;
        open_window();
        send_preamble();
        push_exp(0, 69, 7'd5);
        send_word(cac ^ FLIP5, 64);
        send_fill(1'b0, 3);
        drain("errors_accept");
        thresh = 7'd4; swin = 12'd80;
        open_window();
        send_preamble();
        push_exp(1, 80, 7'd0);
        send_word(cac ^ FLIP5, 64);
        send_fill(1'b0, 12);
        drain("errors_reject");
    endtask

    task automatic test_async_reset();
        thresh = 7'd0; swin = 12'd0;
        open_window();
        send_fill(1'b1, 10);
        checks++;
        if (searching !== 1'b1) begin errors++; $display("FAIL areset_pre: got searching=%b expected 1", searching); end
        #2 rstz = 1'b0;
        #1;
        checks += 2;
        if (searching !== 1'b0) begin errors++; $display("FAIL areset_searching: got %b expected 0", searching); end
        if (corr_errcnt !== 7'd0 || found_clk !== 28'd0) begin
            errors++;
            $display("FAIL areset_regs: got errcnt=%0d found_clk=%h expected 0 and 0", corr_errcnt, found_clk);
        end
        tick();
        rstz = 1'b1;
        tick();
        q.delete();
        found_cnt = 0;
    endtask

    task automatic test_timeout();
        thresh = 7'd0; swin = 12'd100;
        open_window();
        push_exp(1, 100, 7'd0);
        for (int i = 0; i < 99; i++) send_bit(1'($urandom_range(0, 1)));
        checks++;
        if (searching !== 1'b1) begin errors++; $display("FAIL timeout_pre: got searching=%b expected 1", searching); end
        send_bit(1'($urandom_range(0, 1)));
        send_fill(1'b0, 3);
        drain("timeout");
        checks++;
        if (searching !== 1'b0) begin errors++; $display("FAIL timeout_idle: got searching=%b expected 0", searching); end
    endtask

    task automatic test_boundary();
        thresh = 7'd0; swin = 12'd100;
        open_window();
        push_exp(0, 101, 7'd0);
        send_fill(1'b0, 36);
        send_word(cac, 64);
        send_fill(1'b0, 5);
        drain("boundary");
    endtask

    task automatic test_abort();
        thresh = 7'd0; swin = 12'd0;
        open_window();
        send_preamble();
        send_word(cac, 61);
        corr_abort = 1'b1;
        tick();
        corr_abort = 1'b0;
        send_bit(cac[2]); send_bit(cac[1]); send_bit(cac[0]);
        send_fill(1'b0, 3);
        checks++;
        if (searching !== 1'b0) begin errors++; $display("FAIL abort_idle: got searching=%b expected 0", searching); end
        drain("abort");
        corr_abort = 1'b1; corr_win_open = 1'b1;
        tick();
        corr_abort = 1'b0; corr_win_open = 1'b0;
        checks++;
        if (searching !== 1'b0) begin errors++; $display("FAIL abort_vs_open: got searching=%b expected 0", searching); end
        open_window();
        send_preamble();
        push_exp(0, 69, 7'd0);
        send_word(cac, 64);
        send_fill(1'b0, 3);
        drain("abort_reopen");
    endtask

    task automatic test_restart();
        thresh = 7'd0; swin = 12'd0;
        open_window();
        send_preamble();
        send_word(cac, 64);
        repeat (3) tick();
        checks++;
        if (found_cnt != 1 || searching !== 1'b0) begin
            errors++;
            $display("FAIL restart_match: got found=%0d searching=%b expected 1 and 0", found_cnt, searching);
        end
        open_window();
        send_preamble();
        push_exp(0, 69, 7'd0);
        send_word(cac, 64);
        send_fill(1'b0, 3);
        drain("restart");
    endtask

    task automatic test_modes();
        conns = 1'b0; inquiry = 1'b1; thresh = 7'd0; swin = 12'd0;
        for (int d = 0; d < 2; d++) begin
            regi_inquiryDIAC = 1'(d);
            open_window();
            send_preamble();
            send_word(dac, 64);
            send_fill(1'b0, 3);
            checks++;
            if (searching !== 1'b1 || found_cnt != 0) begin
                errors++;
                $display("FAIL mode%0d_dac: got searching=%b found=%0d expected 1 and 0", d, searching, found_cnt);
            end
            open_window();
            send_preamble();
            push_exp(0, 69, 7'd0);
            send_word((d == 0) ? giac : diac, 64);
            send_fill(1'b0, 3);
            drain((d == 0) ? "mode_giac" : "mode_diac");
        end
    endtask

    initial begin
        cac  = 64'hA5F0_1234_5678_9ABC;
        dac  = 64'h3C96_E1D2_4B87_0F5A;
        diac = 64'h7E81_55AA_C33C_9966;
        giac = 64'h9E8B_33DF_A076_2C45;
        test_reset();
        test_exact();
        test_errors();
        test_async_reset();
        test_timeout();
        test_boundary();
        test_abort();
        test_restart();
        test_modes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
